// File: rtl/gray_code_pipe.sv
// Pipelined Gray<->binary converter with valid/ready flow control and a Gray step checker.
// Gray-to-binary is resolved one CHUNK of bits per stage; binary-to-Gray is done in stage 0.
module gray_code_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             out_mode,
    output logic             out_step_err
);

    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] mode_reg;
    logic [STAGES-1:0] err_reg;
    logic [WIDTH-1:0]  data_reg [STAGES];

    logic [STAGES-1:0] stage_load;
    logic [STAGES-1:0] prev_valid;
    logic [STAGES-1:0] prev_mode;
    logic [STAGES-1:0] prev_err;
    logic [WIDTH-1:0]  prev_data  [STAGES];
    logic [WIDTH-1:0]  stage_next [STAGES];

    logic [WIDTH-1:0]  ref_reg;
    logic              ref_valid_reg;
    logic [WIDTH-1:0]  ref_diff;
    logic              step_err;
    logic              accept;
    logic              full_tail;

    // A stage may load unless it and every stage after it are full and the sink is stalled.
    always_comb begin : load_logic
        stage_load = '0;
        full_tail  = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail     = full_tail & valid_reg[k];
            stage_load[k] = !full_tail || out_ready;
        end
    end

    assign in_ready = stage_load[0];
    assign accept   = in_valid && in_ready;

    // Distance > 1 is detected by clearing the lowest set bit and testing for any remainder.
    assign ref_diff = din ^ ref_reg;
    assign step_err = !in_mode && ref_valid_reg &&
                      ((ref_diff & (ref_diff - WIDTH'(1))) != '0);

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int HI = WIDTH - 1 - gi * CHUNK;
            localparam int LO = (WIDTH - (gi + 1) * CHUNK > 0) ? (WIDTH - (gi + 1) * CHUNK) : 0;

            logic [WIDTH-1:0] g2b;
            logic             acc_bit;

            if (gi == 0) begin : g_head
                assign prev_valid[gi] = in_valid;
                assign prev_mode[gi]  = in_mode;
                assign prev_err[gi]   = step_err;
                assign prev_data[gi]  = din;
            end else begin : g_body
                assign prev_valid[gi] = valid_reg[gi-1];
                assign prev_mode[gi]  = mode_reg[gi-1];
                assign prev_err[gi]   = err_reg[gi-1];
                assign prev_data[gi]  = data_reg[gi-1];
            end

            // Bits above HI are already binary, so the chain seeds from the bit just above the chunk.
            always_comb begin
                g2b     = prev_data[gi];
                acc_bit = 1'b0;
                for (int b = WIDTH - 1; b >= 0; b--) begin
                    if (b > HI) begin
                        acc_bit = prev_data[gi][b];
                    end else if (b >= LO) begin
                        acc_bit = acc_bit ^ prev_data[gi][b];
                        g2b[b]  = acc_bit;
                    end
                end
            end

            if (gi == 0) begin : g_b2g
                assign stage_next[gi] = prev_mode[gi] ? (din ^ (din >> 1)) : g2b;
            end else begin : g_pass
                assign stage_next[gi] = prev_mode[gi] ? prev_data[gi] : g2b;
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            valid_reg     <= '0;
            mode_reg      <= '0;
            err_reg       <= '0;
            ref_reg       <= '0;
            ref_valid_reg <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (stage_load[k]) begin
                    valid_reg[k] <= prev_valid[k];
                    if (prev_valid[k]) begin
                        data_reg[k] <= stage_next[k];
                        mode_reg[k] <= prev_mode[k];
                        err_reg[k]  <= prev_err[k];
                    end
                end
            end
            if (accept && !in_mode) begin
                ref_reg       <= din;
                ref_valid_reg <= 1'b1;
            end
        end
    end

    assign out_valid    = valid_reg[STAGES-1];
    assign dout         = data_reg[STAGES-1];
    assign out_mode     = mode_reg[STAGES-1];
    assign out_step_err = err_reg[STAGES-1];

endmodule

// File: tb/tb_gray_code_pipe.sv
// Self-checking bench for gray_code_pipe: an 8-bit/3-stage instance checked against a
// behavioural scoreboard, plus small instances for the shallow and fully-unrolled depths.
module tb_gray_code_pipe;

    typedef struct packed {
        logic       mode;
        logic       err;
        logic [7:0] data;
    } word_t;

    logic       clock = 1'b0;
    logic       aclr  = 1'b1;

    logic       in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
    logic [7:0] din = '0;
    logic       in_ready, out_valid, out_mode, out_step_err;
    logic [7:0] dout;

    logic       small_ready = 1'b1;
    logic       s4_iv = 1'b0, s4_im = 1'b0, s4_ir, s4_ov, s4_om, s4_oe;
    logic [3:0] s4_d = '0, s4_q;
    logic       s5a_iv = 1'b0, s5a_im = 1'b0, s5a_ir, s5a_ov, s5a_om, s5a_oe;
    logic [4:0] s5a_d = '0, s5a_q;
    logic       s5b_iv = 1'b0, s5b_im = 1'b0, s5b_ir, s5b_ov, s5b_om, s5b_oe;
    logic [4:0] s5b_d = '0, s5b_q;

    int         checks = 0;
    int         errors = 0;
    word_t      q[$];
    logic [7:0] m_ref = '0;
    logic       m_ref_valid = 1'b0;

    always #5 clock = ~clock;

    gray_code_pipe #(.WIDTH(8), .STAGES(3)) dut (
        .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .din(din), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .out_mode(out_mode), .out_step_err(out_step_err)
    );

    gray_code_pipe #(.WIDTH(4), .STAGES(2)) dut4 (
        .clock(clock), .aclr(aclr), .in_valid(s4_iv), .in_ready(s4_ir),
        .in_mode(s4_im), .din(s4_d), .out_valid(s4_ov), .out_ready(small_ready),
        .dout(s4_q), .out_mode(s4_om), .out_step_err(s4_oe)
    );

    gray_code_pipe #(.WIDTH(5), .STAGES(1)) dut5a (
        .clock(clock), .aclr(aclr), .in_valid(s5a_iv), .in_ready(s5a_ir),
        .in_mode(s5a_im), .din(s5a_d), .out_valid(s5a_ov), .out_ready(small_ready),
        .dout(s5a_q), .out_mode(s5a_om), .out_step_err(s5a_oe)
    );

    gray_code_pipe #(.WIDTH(5), .STAGES(5)) dut5b (
        .clock(clock), .aclr(aclr), .in_valid(s5b_iv), .in_ready(s5b_ir),
        .in_mode(s5b_im), .din(s5b_d), .out_valid(s5b_ov), .out_ready(small_ready),
        .dout(s5b_q), .out_mode(s5b_om), .out_step_err(s5b_oe)
    );

    // Reference: find the count whose Gray code matches, rather than unrolling an XOR chain.
    function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
        logic [7:0] nb;
        for (int n = 0; n < 256; n++) begin
            nb = n[7:0];
            if ((nb ^ (nb >> 1)) == g) return nb;
        end
        return 8'h00;
    endfunction

    function automatic word_t model_accept(input logic m, input logic [7:0] d);
        word_t w;
        w.mode = m;
        if (m) begin
            w.data = d ^ (d >> 1);
            w.err  = 1'b0;
        end else begin
            w.data      = gray_to_bin(d);
            w.err       = m_ref_valid && ($countones(d ^ m_ref) > 1);
            m_ref       = d;
            m_ref_valid = 1'b1;
        end
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        aclr = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; din = '0; out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        aclr = 1'b0;
        q.delete();
        m_ref = '0;
        m_ref_valid = 1'b0;
    endtask

    // Drives one cycle, reports what the DUT shows before the edge and keeps the scoreboard.
    task automatic step(input logic v, input logic m, input logic [7:0] d, input logic r,
                        output logic ir, output logic ov, output logic got, output int occ,
                        output word_t obs, output word_t exp, output logic exp_ok);
        @(negedge clock);
        in_valid = v; in_mode = m; din = d; out_ready = r;
        #1;
        ir     = in_ready;
        ov     = out_valid;
        got    = out_valid && r;
        occ    = q.size();
        obs    = {out_mode, out_step_err, dout};
        exp    = '0;
        exp_ok = 1'b1;
        if (got) begin
            if (q.size() == 0) exp_ok = 1'b0;
            else exp = q.pop_front();
        end
        if (v && ir) q.push_back(model_accept(m, d));
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode: got %b expected 0", out_mode); end
        checks++; if (out_step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err: got %b expected 0", out_step_err); end
        $display("reset: out_valid=%b in_ready=%b dout=%h", out_valid, in_ready, dout);
    endtask

    task automatic test_small_depths();
        int lat4, lat5a, lat5b;
        logic [3:0] v4, e4d;
        logic [4:0] v5a, v5b, e5d;
        logic e4;
        for (int round = 0; round < 2; round++) begin
            e4d = (round == 1) ? 4'b1101 : 4'b1001;
            e5d = (round == 1) ? 5'b11111 : 5'b10101;
            @(negedge clock);
            s4_iv = 1'b1; s5a_iv = 1'b1; s5b_iv = 1'b1;
            s4_im = round[0]; s5a_im = round[0]; s5b_im = round[0];
            s4_d  = (round == 1) ? 4'b1001 : 4'b1101;
            s5a_d = (round == 1) ? 5'b10101 : 5'b11111;
            s5b_d = s5a_d;
            lat4 = -1; lat5a = -1; lat5b = -1;
            v4 = '0; v5a = '0; v5b = '0; e4 = 1'b1;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clock);
                s4_iv = 1'b0; s5a_iv = 1'b0; s5b_iv = 1'b0;
                #1;
                if (s4_ov && lat4 < 0) begin lat4 = c; v4 = s4_q; e4 = s4_oe; end
                if (s5a_ov && lat5a < 0) begin lat5a = c; v5a = s5a_q; end
                if (s5b_ov && lat5b < 0) begin lat5b = c; v5b = s5b_q; end
            end
            checks++; if (lat4 !== 2) begin errors++; $display("FAIL w4s2_latency: got %0d expected 2", lat4); end
            checks++; if (v4 !== e4d) begin errors++; $display("FAIL w4s2_dout: got %b expected %b", v4, e4d); end
            checks++; if (e4 !== 1'b0) begin errors++; $display("FAIL w4s2_step_err: got %b expected 0", e4); end
            checks++; if (lat5a !== 1) begin errors++; $display("FAIL w5s1_latency: got %0d expected 1", lat5a); end
            checks++; if (v5a !== e5d) begin errors++; $display("FAIL w5s1_dout: got %b expected %b", v5a, e5d); end
            checks++; if (lat5b !== 5) begin errors++; $display("FAIL w5s5_latency: got %0d expected 5", lat5b); end
            checks++; if (v5b !== e5d) begin errors++; $display("FAIL w5s5_dout: got %b expected %b", v5b, e5d); end
            $display("small mode=%0d: w4 %b lat %0d, w5s1 %b lat %0d, w5s5 %b lat %0d",
                     round, v4, lat4, v5a, lat5a, v5b, lat5b);
        end
    endtask

    task automatic test_sweep();
        logic ir, ov, got, ok; int occ, idx; word_t obs, exp; logic [7:0] cb;
        do_reset();
        idx = 0;
        for (int c = 0; c < 300 && idx < 256; c++) begin
            cb = c[7:0];
            step(c < 256, 1'b0, cb ^ (cb >> 1), 1'b1, ir, ov, got, occ, obs, exp, ok);
            checks++; if (ir !== 1'b1) begin errors++; $display("FAIL sweep_in_ready: cycle %0d got %b expected 1", c, ir); end
            if (got) begin
                checks++; if (obs.data !== idx[7:0]) begin errors++; $display("FAIL sweep_data: got %h expected %h", obs.data, idx[7:0]); end
                checks++; if (obs.err !== 1'b0) begin errors++; $display("FAIL sweep_step_err: word %0d got %b expected 0", idx, obs.err); end
                checks++; if (c !== idx + 3) begin errors++; $display("FAIL sweep_timing: word %0d at cycle %0d expected %0d", idx, c, idx + 3); end
                checks++; if (!ok || obs !== exp) begin errors++; $display("FAIL sweep_model: got %h expected %h", obs, exp); end
                idx++;
            end
        end
        checks++; if (idx !== 256) begin errors++; $display("FAIL sweep_count: got %0d expected 256", idx); end
        $display("sweep: %0d words out", idx);
    endtask

    task automatic test_step_check();
        logic ir, ov, got, ok; int occ, n; word_t obs, exp;
        logic [7:0] seq_d [6];
        logic [5:0] seq_m, want_err;
        seq_d[0] = 8'h00; seq_d[1] = 8'h01; seq_d[2] = 8'h01;
        seq_d[3] = 8'h07; seq_d[4] = 8'h0F; seq_d[5] = 8'h06;
        seq_m    = 6'b010000;
        want_err = 6'b001000;
        do_reset();
        n = 0;
        for (int c = 0; c < 20 && n < 6; c++) begin
            step(c < 6, (c < 6) ? seq_m[c] : 1'b0, (c < 6) ? seq_d[c] : 8'h00, 1'b1,
                 ir, ov, got, occ, obs, exp, ok);
            if (got) begin
                checks++; if (obs.err !== want_err[n]) begin errors++; $display("FAIL step_err: word %0d got %b expected %b", n, obs.err, want_err[n]); end
                checks++; if (!ok || obs !== exp) begin errors++; $display("FAIL step_model: word %0d got %h expected %h", n, obs, exp); end
                $display("step word %0d: mode=%b dout=%h err=%b", n, obs.mode, obs.data, obs.err);
                n++;
            end
        end
        checks++; if (n !== 6) begin errors++; $display("FAIL step_count: got %0d expected 6", n); end
    endtask

    task automatic test_backpressure();
        logic ir, ov, got, ok; int occ, acc_cnt, out_cnt; word_t obs, exp, held;
        do_reset();
        acc_cnt = 0; out_cnt = 0; held = '0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, ir, ov, got, occ, obs, exp, ok);
            if (ir) acc_cnt++;
            checks++; if (ir !== (c < 3)) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", c, ir, c < 3); end
            if (c >= 3) begin
                checks++; if (ov !== 1'b1) begin errors++; $display("FAIL bp_out_valid: cycle %0d got %b expected 1", c, ov); end
                if (c == 3) held = obs;
                else begin
                    checks++; if (obs !== held) begin errors++; $display("FAIL bp_hold: got %h expected %h", obs, held); end
                end
            end
        end
        for (int c = 0; c < 30 && (c < 4 || q.size() != 0); c++) begin
            step(c < 4, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1, ir, ov, got, occ, obs, exp, ok);
            if (c < 4 && ir) acc_cnt++;
            if (got) begin
                out_cnt++;
                checks++; if (!ok || obs !== exp) begin errors++; $display("FAIL bp_order: got %h expected %h", obs, exp); end
            end
        end
        checks++; if (out_cnt !== acc_cnt) begin errors++; $display("FAIL bp_count: got %0d expected %0d", out_cnt, acc_cnt); end
        $display("backpressure: accepted %0d delivered %0d", acc_cnt, out_cnt);
    endtask

    task automatic test_reset_mid();
        logic ir, ov, got, ok, seen; word_t obs, exp; int occ;
        do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, ir, ov, got, occ, obs, exp, ok);
        step(1'b1, 1'b0, 8'h01, 1'b0, ir, ov, got, occ, obs, exp, ok);
        @(negedge clock);
        in_valid = 1'b0;
        aclr = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
        @(negedge clock);
        aclr = 1'b0;
        q.delete();
        m_ref = '0;
        m_ref_valid = 1'b0;
        seen = 1'b0;
        step(1'b1, 1'b0, 8'hFF, 1'b1, ir, ov, got, occ, obs, exp, ok);
        for (int c = 0; c < 10 && !seen; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, ir, ov, got, occ, obs, exp, ok);
            if (got) begin
                seen = 1'b1;
                checks++; if (obs.err !== 1'b0) begin errors++; $display("FAIL midreset_step_err: got %b expected 0", obs.err); end
                checks++; if (obs.data !== 8'hAA) begin errors++; $display("FAIL midreset_dout: got %h expected aa", obs.data); end
                checks++; if (!ok || obs !== exp) begin errors++; $display("FAIL midreset_model: got %h expected %h", obs, exp); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL midreset_timeout: got no output expected one word"); end
        $display("reset mid-operation: first word after release seen=%b", seen);
    endtask

    task automatic test_random();
        logic ir, ov, got, ok, v, m, r; int occ, outs; word_t obs, exp; logic [7:0] d, last;
        do_reset();
        last = '0; outs = 0;
        for (int c = 0; c < 600; c++) begin
            v = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       d = 8'($urandom);
                1:       d = last;
                default: d = last ^ (8'h01 << $urandom_range(0, 7));
            endcase
            step(v, m, d, r, ir, ov, got, occ, obs, exp, ok);
            if (v && ir && !m) last = d;
            checks++; if (ir !== (occ < 3 || r)) begin errors++; $display("FAIL rand_in_ready: cycle %0d got %b expected %b", c, ir, occ < 3 || r); end
            if (got) begin
                outs++;
                checks++; if (!ok || obs !== exp) begin errors++; $display("FAIL rand_word: cycle %0d got %h expected %h", c, obs, exp); end
            end
        end
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, ir, ov, got, occ, obs, exp, ok);
            if (got) begin
                outs++;
                checks++; if (!ok || obs !== exp) begin errors++; $display("FAIL rand_drain: got %h expected %h", obs, exp); end
            end
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand_undelivered: got %0d left expected 0", q.size()); end
        $display("random: %0d words delivered", outs);
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        test_reset();
        aclr = 1'b0;
        test_small_depths();
        test_sweep();
        test_step_check();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
